// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access runs IDLE -> ACCESS -> RESP, so at most one access completes every 3 cycles.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic [2:0]            ctrl0_i,
  input  logic [2:0]            ctrl1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_ctrl_o,
  output logic                  mem_we_o,
  output logic                  mem_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state;
  logic                  owner, last_owner, winner;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            ctrl_q;

  logic [1:0][ADDR_WIDTH-1:0] addr_v;
  logic [1:0][DATA_WIDTH-1:0] wdata_v;
  logic [1:0][2:0]            ctrl_v;

  assign addr_v  = {addr1_i, addr0_i};
  assign wdata_v = {wdata1_i, wdata0_i};
  assign ctrl_v  = {ctrl1_i, ctrl0_i};

  // Sole requester wins; on a tie the one that did not go last wins.
  always_comb begin
    winner = 1'b0;
    case (req_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req_i != 2'b00) begin
          state      <= ACCESS;
          owner      <= winner;
          last_owner <= winner;
          we_q       <= we_i[winner];
          addr_q     <= addr_v[winner];
          wdata_q    <= wdata_v[winner];
          ctrl_q     <= ctrl_v[winner];
        end
        ACCESS:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic in_access, in_resp;
  logic [1:0] owner_oh;
  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);
  assign owner_oh  = owner ? 2'b10 : 2'b01;

  // Reset clears state asynchronously, so every output below drops with it.
  assign gnt_o       = in_access ? owner_oh : 2'b00;
  assign rvalid_o    = in_resp   ? owner_oh : 2'b00;
  assign rdata_o     = in_resp   ? mem_rdata_i : '0;
  assign mem_en_o    = in_access;
  assign mem_we_o    = in_access & we_q;
  assign mem_addr_o  = in_access ? addr_q  : '0;
  assign mem_wdata_o = in_access ? wdata_q : '0;
  assign mem_ctrl_o  = in_access ? ctrl_q  : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioral memory.
module tb_mem_arbiter;
  logic        clk, rst;
  logic [1:0]  req, we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  ctrl0, ctrl1;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_ctrl;
  logic        mem_we, mem_en;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ctrl0_i(ctrl0), .ctrl1_i(ctrl1), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ctrl_o(mem_ctrl),
    .mem_we_o(mem_we), .mem_en_o(mem_en), .mem_rdata_i(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en_we: got %b%b want 00", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL reset_addr_rdata: got %h/%h want 0/0", mem_addr, rdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_store();
    req = 2'b01; we = 2'b01; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; ctrl0 = 3'b010;
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL store_gnt: got %b want 01", gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL store_en_we: got %b%b want 11", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL store_addr: got %h want 10", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF || mem_ctrl !== 3'b010) begin errors++; $display("FAIL store_wdata_ctrl: got %h/%b want deadbeef/010", mem_wdata, mem_ctrl); end
    req = 2'b00;
    step();
    checks++; if (rvalid !== 2'b01 || gnt !== 2'b00) begin errors++; $display("FAIL store_rvalid: got rvalid %b gnt %b want 01/00", rvalid, gnt); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL store_resp_idle_bus: got en %b addr %h want 0/0", mem_en, mem_addr); end
    step();
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL store_rvalid_pulse: got %b want 00", rvalid); end
  endtask

  task automatic test_load();
    req = 2'b01; we = 2'b00; addr0 = 32'h10;
    step();
    checks++; if (gnt !== 2'b01 || mem_we !== 1'b0) begin errors++; $display("FAIL load_gnt: got gnt %b we %b want 01/0", gnt, mem_we); end
    req = 2'b00;
    step();
    checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL load_rvalid: got %b want 01", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rdata); end
    step();
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL load_rdata_idle: got %h want 0", rdata); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g, exp_r;
    rst = 1'b1; step(); rst = 1'b0;
    req = 2'b11; we = 2'b00; addr0 = 32'h10; addr1 = 32'h14;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_g = (c % 3 == 1) ? ((((c - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_r = (c % 3 == 2) ? ((((c - 2) / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b want %b", c, gnt, exp_g); end
      checks++; if (rvalid !== exp_r) begin errors++; $display("FAIL rr_rvalid cycle %0d: got %b want %b", c, rvalid, exp_r); end
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_addr_hold();
    req = 2'b10; we = 2'b00; addr1 = 32'h40; ctrl1 = 3'b101;
    step();
    addr1 = 32'h44;
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL hold_gnt: got %b want 10", gnt); end
    checks++; if (mem_addr !== 32'h40 || mem_ctrl !== 3'b101) begin errors++; $display("FAIL hold_addr: got %h/%b want 40/101", mem_addr, mem_ctrl); end
    req = 2'b00;
    step();
    checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL hold_rvalid: got %b want 10", rvalid); end
    step();
  endtask

  task automatic test_reset_abort();
    req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'h12345678;
    step();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL abort_pre_we: got %b want 1", mem_we); end
    req = 2'b00;
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_en !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL abort_async: got we %b en %b gnt %b want 0/0/00", mem_we, mem_en, gnt); end
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL abort_no_rvalid %0d: got %b want 00", c, rvalid); end
    end
    req = 2'b11; we = 2'b00;
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL abort_first_tie: got %b want 01", gnt); end
    req = 2'b00;
    step(); step();
  endtask

  task automatic test_back_to_back();
    req = 2'b01; we = 2'b00; addr0 = 32'h10;
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_gnt0: got %b want 01", gnt); end
    req = 2'b00;
    step();
    req = 2'b10; addr1 = 32'h10;
    #1;
    checks++; if (gnt !== 2'b00 || rvalid !== 2'b01) begin errors++; $display("FAIL b2b_resp: got gnt %b rvalid %b want 00/01", gnt, rvalid); end
    step();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b want 00", gnt); end
    step();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL b2b_gnt1: got %b want 10", gnt); end
    req = 2'b00;
    step();
    checks++; if (rvalid !== 2'b10 || rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata1: got %b/%h want 10/deadbeef", rvalid, rdata); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; ctrl0 = '0; ctrl1 = '0;
    test_reset();
    test_store();
    test_load();
    test_round_robin();
    test_addr_hold();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width of each port and of the memory.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the read/write data width.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, reset; asynchronous, active-high.
REQ-005 The block SHALL have port req_i, input, 2 bits, one access request per requester (bit 0 = core load/store port, bit 1 = loader/debug port).
REQ-006 The block SHALL have port we_i, input, 2 bits, per-requester write enable (1 = store, 0 = load).
REQ-007 The block SHALL have ports addr0_i and addr1_i, input, ADDR_WIDTH each, per-requester address.
REQ-008 The block SHALL have ports wdata0_i and wdata1_i, input, DATA_WIDTH each, per-requester store data.
REQ-009 The block SHALL have ports ctrl0_i and ctrl1_i, input, 3 bits each, per-requester access size/sign code, passed through unmodified.
REQ-010 The block SHALL have port gnt_o, output, 2 bits, one-cycle grant pulse to the winning requester.
REQ-011 The block SHALL have port rvalid_o, output, 2 bits, one-cycle completion pulse (load data valid or store done).
REQ-012 The block SHALL have port rdata_o, output, DATA_WIDTH, load data shared by both requesters, qualified by rvalid_o.
REQ-013 The block SHALL have ports mem_addr_o (ADDR_WIDTH), mem_wdata_o (DATA_WIDTH), mem_ctrl_o (3), mem_we_o (1) and mem_en_o (1), all outputs, driving the single-port data memory.
REQ-014 The block SHALL have port mem_rdata_i, input, DATA_WIDTH, memory read data, valid the cycle after mem_en_o.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS when req_i != 0 at a clock edge, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 On IDLE->ACCESS the block SHALL latch the winner index and the winner's we, addr, wdata and ctrl into registers.
REQ-017 Arbitration SHALL be round-robin: with one request that requester wins; with both, the requester not equal to last_owner wins.
REQ-018 last_owner SHALL update to the winner on the IDLE->ACCESS transition.
REQ-019 In ACCESS the block SHALL drive mem_en_o=1, mem_we_o=latched we, and mem_addr_o/mem_wdata_o/mem_ctrl_o from the latched fields, and SHALL assert gnt_o only for the owner bit.
REQ-020 In RESP the block SHALL assert rvalid_o only for the owner bit and drive rdata_o=mem_rdata_i combinationally; rdata_o SHALL be 0 outside RESP.
REQ-021 Outside ACCESS, mem_en_o and mem_we_o SHALL be 0, and mem_addr_o, mem_wdata_o and mem_ctrl_o SHALL be 0.
REQ-022 Latency SHALL be fixed: request sampled at edge N, gnt_o high in cycle N+1, rvalid_o high in cycle N+2; the next grant is no earlier than cycle N+4 (one access per 3 cycles).
REQ-023 Requesters SHALL hold req/we/addr/wdata/ctrl stable until gnt_o; changes to those inputs after the latch SHALL NOT affect the access in flight.
REQ-024 Requests arriving in ACCESS or RESP SHALL be ignored until IDLE; a requester still asserting req_i in IDLE SHALL be arbitrated again, and the round-robin rule SHALL prevent starvation when both requesters hold their requests continuously.
REQ-025 gnt_o and rvalid_o SHALL each be one-hot or zero at all times.

Reset
REQ-026 While rst_i=1, regardless of clk_i, the block SHALL set the state to IDLE and last_owner=1 (port 0 wins the first tie), and SHALL force all outputs to 0.
REQ-027 Reset asserted during ACCESS SHALL drop mem_we_o immediately, and no rvalid_o SHALL be issued for the aborted access.

Verification
REQ-028 The bench SHALL cover: after reset, req_i=01, we_i=01, addr0=0x10, wdata0=0xDEADBEEF -> gnt_o=01 with mem_we_o=1 and mem_addr_o=0x10 the next cycle, then rvalid_o=01.
REQ-029 The bench SHALL cover: load after that store, req_i=01, we_i=00, addr0=0x10 -> gnt_o=01, then rvalid_o=01 with rdata_o=0xDEADBEEF.
REQ-030 The bench SHALL cover: both requesters held at req_i=11 from reset -> grants alternate 01, 10, 01, 10, spaced 3 cycles apart.
REQ-031 The bench SHALL cover: req_i=10 with addr1 changed to 0x44 one cycle after the sample (was 0x40) -> mem_addr_o=0x40.
REQ-032 The bench SHALL cover: rst_i pulsed mid-ACCESS of a store -> mem_we_o=0 asynchronously, no rvalid_o, and the next req_i=11 is granted to port 0.
REQ-033 The bench SHALL cover: req_i=01 then req_i=10 raised during RESP -> port 1 is granted in the cycle after the return to IDLE, and there is no overlapping gnt_o.
